// File: rtl/cdc_pkg.sv
// Shared definitions for the clkb-domain edge filter: FSM encodings and defaults.
package cdc_pkg;

   // Default number of consecutive samples needed to accept a level change.
   localparam int STABLE_CYC_DEF = 4;
   // Default width of the accepted-rise event counter.
   localparam int CNT_W_DEF      = 8;
   // Filter counter width; wide enough for the largest legal STABLE_CYC (255).
   localparam int FCNT_W         = 8;

   // Filter FSM: two stable levels, each with a matching "checking" state.
   typedef enum logic [1:0] {
      IDLE_LO = 2'b00,
      CHK_HI  = 2'b01,
      IDLE_HI = 2'b10,
      CHK_LO  = 2'b11
   } filt_state_e;

endpackage : cdc_pkg

// File: rtl/sync_edge_filter_if.sv
// Bundles the filter's data/event signals so a bench or wrapper can pass them around as one.
interface sync_edge_filter_if
   import cdc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);

   logic             din;
   logic             clr;
   logic             evt_ack;
   logic             level_out;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] evt_cnt;
   logic             cnt_sat;
   logic             evt_valid;
   logic             evt_type;
   logic             overrun;

   // Producer/consumer side: drives the level, clear and acknowledge.
   modport master (
      output din, clr, evt_ack,
      input  level_out, rise_pulse, fall_pulse, evt_cnt, cnt_sat,
             evt_valid, evt_type, overrun
   );

   // Filter side: samples the inputs and drives the results.
   modport slave (
      input  din, clr, evt_ack,
      output level_out, rise_pulse, fall_pulse, evt_cnt, cnt_sat,
             evt_valid, evt_type, overrun
   );

endinterface : sync_edge_filter_if

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; the saturation flag is registered alongside the count.
module sat_counter
   import cdc_pkg::*;
#(
   parameter int W = CNT_W_DEF
) (
   input  logic         clkb,
   input  logic         rstn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         sat
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         sat_q, sat_d;

   // Next count: clear wins over increment, and the count sticks at all-ones.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
      sat_d = (cnt_d == '1);
   end

   // Count and flag registers with synchronous active-low reset.
   always_ff @(posedge clkb) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      if (!rstn) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   assign cnt = cnt_q;
   assign sat = sat_q;

endmodule : sat_counter

// File: rtl/sync_edge_filter.sv
// Debounce filter for an already-synchronized level: accepts a change only after
// STABLE_CYC consecutive differing samples, then reports it as a pulse and a pending event.
module sync_edge_filter
   import cdc_pkg::*;
#(
   parameter int STABLE_CYC = STABLE_CYC_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clkb,
   input  logic             rstn,
   input  logic             din,
   input  logic             clr,
   input  logic             evt_ack,
   output logic             level_out,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] evt_cnt,
   output logic             cnt_sat,
   output logic             evt_valid,
   output logic             evt_type,
   output logic             overrun
);

   // The filter count reaches STABLE_CYC-1 after that many differing samples;
   // one more differing sample completes the run.
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(STABLE_CYC - 1);

   filt_state_e       state_q, state_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;

   logic accept_rise, accept_fall, accept_any;

   logic level_q, level_d;
   logic rise_q, fall_q;
   logic evt_valid_q, evt_valid_d;
   logic evt_type_q, evt_type_d;
   logic overrun_q, overrun_d;

   // FSM state and filter count registers; reset aborts any check in progress.
   always_ff @(posedge clkb) begin
      if (!rstn) begin
         state_q <= IDLE_LO;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Next-state logic: enter a check on a differing sample, fall back on a matching one.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         IDLE_LO: begin
            if (din) begin
               state_d = CHK_HI;
               fcnt_d  = FCNT_W'(1);
            end
         end
         CHK_HI: begin
            if (!din) begin
               state_d = IDLE_LO;
               fcnt_d  = '0;
            end else if (fcnt_q == FCNT_LAST) begin
               state_d = IDLE_HI;
               fcnt_d  = '0;
            end else begin
               fcnt_d = fcnt_q + FCNT_W'(1);
            end
         end
         IDLE_HI: begin
            if (!din) begin
               state_d = CHK_LO;
               fcnt_d  = FCNT_W'(1);
            end
         end
         CHK_LO: begin
            if (din) begin
               state_d = IDLE_HI;
               fcnt_d  = '0;
            end else if (fcnt_q == FCNT_LAST) begin
               state_d = IDLE_LO;
               fcnt_d  = '0;
            end else begin
               fcnt_d = fcnt_q + FCNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE_LO;
            fcnt_d  = '0;
         end
      endcase
   end

   // FSM outputs: an edge is accepted on the sample that completes a stable run.
   always_comb begin
      accept_rise = (state_q == CHK_HI) &&  din && (fcnt_q == FCNT_LAST);
      accept_fall = (state_q == CHK_LO) && !din && (fcnt_q == FCNT_LAST);
      accept_any  = accept_rise || accept_fall;
   end

   // Event bookkeeping: a new edge always wins over an ack; overrun only when an unacked event is overwritten.
   always_comb begin
      level_d     = level_q;
      evt_valid_d = evt_valid_q;
      evt_type_d  = evt_type_q;
      overrun_d   = overrun_q;
      if (accept_rise) begin
         level_d = 1'b1;
      end else if (accept_fall) begin
         level_d = 1'b0;
      end
      if (accept_any) begin
         evt_valid_d = 1'b1;
         evt_type_d  = accept_rise;
         if (evt_valid_q && !evt_ack) begin
            overrun_d = 1'b1;
         end
      end else if (evt_valid_q && evt_ack) begin
         evt_valid_d = 1'b0;
      end
      if (clr) begin
         overrun_d = 1'b0;
      end
   end

   // Registered outputs, so nothing downstream sees a combinational path from din.
   always_ff @(posedge clkb) begin
      if (!rstn) begin
         level_q     <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_type_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         level_q     <= level_d;
         rise_q      <= accept_rise;
         fall_q      <= accept_fall;
         evt_valid_q <= evt_valid_d;
         evt_type_q  <= evt_type_d;
         overrun_q   <= overrun_d;
      end
   end

   // Rising-edge counter; it increments on the same edge that registers rise_pulse.
   sat_counter #(
      .W (CNT_W)
   ) u_evt_cnt (
      .clkb (clkb),
      .rstn (rstn),
      .clr  (clr),
      .inc  (accept_rise),
      .cnt  (evt_cnt),
      .sat  (cnt_sat)
   );

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign evt_valid  = evt_valid_q;
   assign evt_type   = evt_type_q;
   assign overrun    = overrun_q;

endmodule : sync_edge_filter

// File: tb/tb_sync_edge_filter.sv
// Directed bench for sync_edge_filter with STABLE_CYC=4, CNT_W=4.
module tb_sync_edge_filter;
   import cdc_pkg::*;

   localparam int SC = 4;
   localparam int CW = 4;

   logic clkb = 1'b0;
   logic rstn = 1'b0;

   sync_edge_filter_if #(.CNT_W(CW)) bus ();

   sync_edge_filter #(
      .STABLE_CYC (SC),
      .CNT_W      (CW)
   ) dut (
      .clkb       (clkb),
      .rstn       (rstn),
      .din        (bus.din),
      .clr        (bus.clr),
      .evt_ack    (bus.evt_ack),
      .level_out  (bus.level_out),
      .rise_pulse (bus.rise_pulse),
      .fall_pulse (bus.fall_pulse),
      .evt_cnt    (bus.evt_cnt),
      .cnt_sat    (bus.cnt_sat),
      .evt_valid  (bus.evt_valid),
      .evt_type   (bus.evt_type),
      .overrun    (bus.overrun)
   );

   always #5 clkb = ~clkb;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Advance one clkb edge and settle away from it.
   task automatic tick();
      @(posedge clkb);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      bus.din = v;
      repeat (n) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " level"},   32'(bus.level_out),  32'd0);
      check({tag, " rise"},    32'(bus.rise_pulse), 32'd0);
      check({tag, " fall"},    32'(bus.fall_pulse), 32'd0);
      check({tag, " cnt"},     32'(bus.evt_cnt),    32'd0);
      check({tag, " sat"},     32'(bus.cnt_sat),    32'd0);
      check({tag, " valid"},   32'(bus.evt_valid),  32'd0);
      check({tag, " type"},    32'(bus.evt_type),   32'd0);
      check({tag, " overrun"}, 32'(bus.overrun),    32'd0);
   endtask

   task automatic ack_once();
      bus.evt_ack = 1'b1;
      tick();
      bus.evt_ack = 1'b0;
   endtask

   task automatic clr_once();
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.din     = 1'b1;
      bus.clr     = 1'b0;
      bus.evt_ack = 1'b0;
      rstn        = 1'b0;

      // Reset held two cycles with din high; then four samples to rise.
      tick();
      check_all_zero("rst1");
      tick();
      check_all_zero("rst2");
      rstn = 1'b1;
      hold(1'b1, 3);
      check("post_rst level before 4th", 32'(bus.level_out), 32'd0);
      check("post_rst rise before 4th",  32'(bus.rise_pulse), 32'd0);
      tick();
      check("post_rst level", 32'(bus.level_out),  32'd1);
      check("post_rst rise",  32'(bus.rise_pulse), 32'd1);
      check("post_rst cnt",   32'(bus.evt_cnt),    32'd1);
      ack_once();
      check("post_rst ack valid", 32'(bus.evt_valid), 32'd0);

      // Return low, then clear the counter.
      hold(1'b0, 3);
      check("fall1 pre", 32'(bus.fall_pulse), 32'd0);
      tick();
      check("fall1 pulse", 32'(bus.fall_pulse), 32'd1);
      check("fall1 level", 32'(bus.level_out),  32'd0);
      check("fall1 type",  32'(bus.evt_type),   32'd0);
      check("fall1 overrun", 32'(bus.overrun),  32'd0);
      tick();
      check("fall1 pulse end", 32'(bus.fall_pulse), 32'd0);
      ack_once();
      clr_once();
      check("clr cnt", 32'(bus.evt_cnt), 32'd0);

      // Glitch: three high samples then low is rejected.
      hold(1'b1, 3);
      check("glitch rise", 32'(bus.rise_pulse), 32'd0);
      hold(1'b0, 1);
      check("glitch level", 32'(bus.level_out),  32'd0);
      check("glitch rise2", 32'(bus.rise_pulse), 32'd0);
      tick();
      check("glitch rise3", 32'(bus.rise_pulse), 32'd0);
      check("glitch cnt",   32'(bus.evt_cnt),    32'd0);
      check("glitch valid", 32'(bus.evt_valid),  32'd0);

      // Clean rise with single-cycle pulse and ack.
      hold(1'b1, 4);
      check("rise rise",  32'(bus.rise_pulse), 32'd1);
      check("rise cnt",   32'(bus.evt_cnt),    32'd1);
      check("rise valid", 32'(bus.evt_valid),  32'd1);
      check("rise type",  32'(bus.evt_type),   32'd1);
      tick();
      check("rise pulse width", 32'(bus.rise_pulse), 32'd0);
      check("rise held valid",  32'(bus.evt_valid),  32'd1);
      ack_once();
      check("rise ack valid", 32'(bus.evt_valid), 32'd0);

      // Overrun: fall (acked), rise, then fall with no ack.
      hold(1'b0, 4);
      ack_once();
      hold(1'b1, 4);
      check("ovr rise cnt", 32'(bus.evt_cnt), 32'd2);
      hold(1'b0, 4);
      check("ovr overrun", 32'(bus.overrun),   32'd1);
      check("ovr type",    32'(bus.evt_type),  32'd0);
      check("ovr valid",   32'(bus.evt_valid), 32'd1);
      // A new edge in the same cycle as the ack keeps the event pending.
      hold(1'b1, 3);
      bus.evt_ack = 1'b1;
      tick();
      bus.evt_ack = 1'b0;
      check("ack+edge valid",   32'(bus.evt_valid), 32'd1);
      check("ack+edge type",    32'(bus.evt_type),  32'd1);
      check("ack+edge overrun", 32'(bus.overrun),   32'd1);
      check("ack+edge cnt",     32'(bus.evt_cnt),   32'd3);
      ack_once();
      check("ovr ack valid", 32'(bus.evt_valid), 32'd0);
      // Ack with nothing pending is ignored.
      ack_once();
      check("idle ack valid",   32'(bus.evt_valid), 32'd0);
      check("idle ack overrun", 32'(bus.overrun),   32'd1);

      // Clear in the same cycle as a rise pulse.
      hold(1'b0, 4);
      ack_once();
      hold(1'b1, 3);
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      check("clr+rise rise",    32'(bus.rise_pulse), 32'd1);
      check("clr+rise cnt",     32'(bus.evt_cnt),    32'd0);
      check("clr+rise overrun", 32'(bus.overrun),    32'd0);
      check("clr+rise valid",   32'(bus.evt_valid),  32'd1);
      ack_once();

      // Reset during CHK_HI after two samples aborts the check.
      hold(1'b0, 4);
      ack_once();
      hold(1'b1, 2);
      rstn = 1'b0;
      tick();
      check_all_zero("chk_rst");
      rstn = 1'b1;
      hold(1'b0, 1);
      check("chk_rst after level", 32'(bus.level_out),  32'd0);
      check("chk_rst after rise",  32'(bus.rise_pulse), 32'd0);
      hold(1'b1, 3);
      check("chk_rst refilter level", 32'(bus.level_out), 32'd0);
      tick();
      check("chk_rst refilter rise", 32'(bus.rise_pulse), 32'd1);
      check("chk_rst refilter cnt",  32'(bus.evt_cnt),    32'd1);
      hold(1'b0, 4);

      // Saturation over 16 filtered rises, ack held high throughout.
      clr_once();
      bus.evt_ack = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         hold(1'b1, 4);
         check($sformatf("sat cnt rise%0d", i), 32'(bus.evt_cnt), (i > 15) ? 32'd15 : 32'(i));
         if (i >= 14)
            check($sformatf("sat flag rise%0d", i), 32'(bus.cnt_sat), (i >= 15) ? 32'd1 : 32'd0);
         hold(1'b0, 4);
      end
      bus.evt_ack = 1'b0;
      check("sat overrun", 32'(bus.overrun), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_sync_edge_filter
